// File: rtl/sha256_digest_uart_tx.sv
// ---------------------------------------------------------------------------
// sha256_digest_uart_tx
//
// Output stage of the SHA-256 core. Accepts one digest from the hash engine
// through a valid/ready handshake and sends it as NUM_BYTES UART 8N1 frames,
// most significant byte first (byte 0 = digest_in[top:top-7]). Each byte is
// sent LSB first.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   digest_in     digest word, sampled only on the handshake edge
//   digest_valid  digest_in is valid
//   digest_ready  block is idle and will accept a digest
//   data_out      UART serial line, idle high, driven from a flop
//   busy          a digest is being transmitted
//   tx_done       one-cycle pulse after the last stop bit of the last byte
// ---------------------------------------------------------------------------
module sha256_digest_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int NUM_BYTES    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BYTES*8-1:0] digest_in,
    input  logic                   digest_valid,
    output logic                   digest_ready,
    output logic                   data_out,
    output logic                   busy,
    output logic                   tx_done
);

    localparam int DW     = NUM_BYTES * 8;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);
    // Stop-period counter only needs one bit: it tracks 1 or 2 stop bits.
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_cnt;
    logic              r_stop_cnt;
    logic [BYTE_W-1:0] r_byte_cnt;
    logic [DW-1:0]     r_shift;
    logic              r_data_out;
    logic              r_ready;
    logic              r_busy;
    logic              r_tx_done;

    state_t            w_state_next;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        w_bit_next;
    logic              w_stop_next;
    logic [BYTE_W-1:0] w_byte_next;
    logic [DW-1:0]     w_shift_next;
    logic              w_data_next;
    logic              w_baud_wrap;
    logic [7:0]        w_cur_byte;

    // Next-state logic. Every register's next value is computed here so the
    // serial output can be registered from the *next* state: the line drops
    // low in the very first START cycle, right after the handshake edge.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit_cnt;
        w_stop_next  = r_stop_cnt;
        w_byte_next  = r_byte_cnt;
        w_shift_next = r_shift;
        w_baud_wrap  = (r_baud == BAUD_LAST);

        if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
            w_baud_next = w_baud_wrap ? '0 : r_baud + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (digest_valid) begin
                    w_state_next = S_START;
                    w_shift_next = digest_in;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_stop_next  = 1'b0;
                    w_byte_next  = '0;
                end
            end
            S_START: begin
                if (w_baud_wrap) begin
                    w_state_next = S_DATA;
                    w_bit_next   = '0;
                end
            end
            S_DATA: begin
                if (w_baud_wrap) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_STOP;
                        w_stop_next  = 1'b0;
                    end else begin
                        w_bit_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_baud_wrap) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        // Byte finished: expose the next byte at the top.
                        w_shift_next = {r_shift[DW-9:0], 8'h00};
                        w_byte_next  = r_byte_cnt + 1'b1;
                        w_state_next = (r_byte_cnt < BYTE_LAST) ? S_START : S_DONE;
                    end else begin
                        w_stop_next = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_cur_byte = w_shift_next[DW-1 -: 8];
        case (w_state_next)
            S_START: w_data_next = 1'b0;
            S_DATA:  w_data_next = w_cur_byte[w_bit_next];
            default: w_data_next = 1'b1;
        endcase
    end

    // NOTE: sequential state is written with <= only, so all flops update
    // together from the values the combinational block computed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_byte_cnt <= '0;
            // NOTE: the shift register is a plain flop vector, not a RAM, so it
            // is cleared with the rest of the state.
            r_shift    <= '0;
            r_data_out <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_stop_cnt <= w_stop_next;
            r_byte_cnt <= w_byte_next;
            r_shift    <= w_shift_next;
            r_data_out <= w_data_next;
            r_ready    <= (w_state_next == S_IDLE);
            r_busy     <= (w_state_next != S_IDLE);
            r_tx_done  <= (w_state_next == S_DONE);
        end
    end

    assign digest_ready = r_ready;
    assign data_out     = r_data_out;
    assign busy         = r_busy;
    assign tx_done      = r_tx_done;

endmodule

// File: tb/tb_sha256_digest_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_sha256_digest_uart_tx
//
// Directed bench for sha256_digest_uart_tx with a short bit period so whole
// digests fit in a brief run. A mid-bit UART receiver collects bytes into a
// queue; each test task drives one scenario and compares inline.
// ---------------------------------------------------------------------------
module tb_sha256_digest_uart_tx;

    localparam int CPB        = 8;
    localparam int NB         = 32;
    localparam int FRAME      = 10 * CPB;     // start + 8 data + 1 stop
    localparam int DIGEST_CYC = NB * FRAME;   // handshake edge -> tx_done edge

    localparam logic [255:0] D1 =
        256'h5f806d26_1a579f2e_eea47739_6394699a_c2deaf34_2ec8da3b_189d8427_25a4a697;
    localparam logic [255:0] D2 =
        256'h0123456789abcdef_0123456789abcdef_0123456789abcdef_0123456789abcdef;

    logic         clk;
    logic         rst;
    logic [255:0] digest_in;
    logic         digest_valid;
    logic         digest_ready;
    logic         data_out;
    logic         busy;
    logic         tx_done;

    int checks;
    int errors;
    int cyc;
    int hs_cyc;
    int done_cnt;
    int frame_err;
    logic [7:0] rx_q[$];

    sha256_digest_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (1),
        .NUM_BYTES   (NB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digest_in   (digest_in),
        .digest_valid(digest_valid),
        .digest_ready(digest_ready),
        .data_out    (data_out),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

    // Mid-bit UART receiver.
    initial begin : uart_rx
        logic       prev;
        logic [7:0] b;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (data_out === 1'b0 && prev === 1'b1) begin
                repeat (CPB / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = data_out;
                end
                repeat (CPB) @(negedge clk);
                if (data_out !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
            prev = data_out;
        end
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded 60000 cycles, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Present a digest at a negedge; returns at the negedge after the
    // handshake edge (first START cycle) with hs_cyc marking that edge.
    task automatic send(input logic [255:0] d, input bit hold);
        @(negedge clk);
        digest_in    = d;
        digest_valid = 1'b1;
        @(negedge clk);
        hs_cyc = cyc;
        if (!hold) digest_valid = 1'b0;
    endtask

    // Wait for tx_done; rel = posedges since handshake edge, -1 on timeout.
    task automatic wait_done(output int rel);
        rel = -1;
        for (int i = 0; i < DIGEST_CYC + 200; i++) begin
            if (tx_done === 1'b1) begin
                rel = cyc - hs_cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst          = 1'b1;
        digest_valid = 1'b1;
        digest_in    = D1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (data_out !== 1'b1 || digest_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_values: bad cycles=%0d, required 0", bad);
        end
        rst          = 1'b0;
        digest_valid = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (data_out !== 1'b1 || digest_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_release_idle: bad cycles=%0d, required 0", bad);
        end
        checks++;
        if (rx_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_no_tx: bytes=%0d, required 0", rx_q.size());
        end
    endtask

    task automatic test_single();
        logic       w[FRAME+1];
        logic [7:0] fb;
        logic       exp;
        int         bad;
        int         rel;
        int         d0;
        rx_q.delete();
        frame_err = 0;
        d0 = done_cnt;
        send(D1, 1'b0);
        checks++;
        if (busy !== 1'b1 || digest_ready !== 1'b0) begin
            errors++;
            $display("FAIL handshake_flags: busy=%b ready=%b, required 1 0", busy, digest_ready);
        end
        w[0] = data_out;
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            w[i] = data_out;
        end
        fb = 8'h5F;
        for (int p = 0; p < 10; p++) begin
            exp = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : fb[p-1];
            bad = 0;
            for (int c = 0; c < CPB; c++) if (w[p*CPB+c] !== exp) bad++;
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL bit_timing period %0d: %0d cycles differ from level %b", p, bad, exp);
            end
        end
        checks++;
        if (w[FRAME] !== 1'b0) begin
            errors++;
            $display("FAIL next_start: data_out=%b, required 0", w[FRAME]);
        end
        wait_done(rel);
        checks++;
        if (rel !== DIGEST_CYC) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles, required %0d", rel, DIGEST_CYC);
        end
        @(negedge clk);
        checks++;
        if (digest_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: ready=%b busy=%b done=%b, required 1 0 0",
                     digest_ready, busy, tx_done);
        end
        repeat (5) @(negedge clk);
        bad = 0;
        for (int i = 0; i < NB; i++)
            if (i >= rx_q.size() || rx_q[i] !== D1[255-8*i -: 8]) bad++;
        checks++;
        if (rx_q.size() !== NB || bad !== 0) begin
            errors++;
            $display("FAIL single_bytes: count=%0d bad=%0d, required %0d 0", rx_q.size(), bad, NB);
        end
        checks++;
        if (done_cnt - d0 !== 1 || frame_err !== 0) begin
            errors++;
            $display("FAIL single_done: pulses=%0d frame_err=%0d, required 1 0",
                     done_cnt - d0, frame_err);
        end
    endtask

    task automatic test_ignored_input();
        int bad;
        int rel;
        rx_q.delete();
        send(D1, 1'b0);
        for (int i = 0; i < 6 * FRAME && rx_q.size() < 5; i++) @(negedge clk);
        repeat (2 * CPB) @(negedge clk);
        digest_in    = '1;
        digest_valid = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (digest_ready !== 1'b0) bad++;
        end
        digest_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ignored_ready: ready high %0d cycles, required 0", bad);
        end
        wait_done(rel);
        checks++;
        if (rel !== DIGEST_CYC) begin
            errors++;
            $display("FAIL ignored_latency: got %0d, required %0d", rel, DIGEST_CYC);
        end
        repeat (5) @(negedge clk);
        bad = 0;
        for (int i = 0; i < NB; i++)
            if (i >= rx_q.size() || rx_q[i] !== D1[255-8*i -: 8]) bad++;
        checks++;
        if (rx_q.size() !== NB || bad !== 0) begin
            errors++;
            $display("FAIL ignored_bytes: count=%0d bad=%0d, required %0d 0", rx_q.size(), bad, NB);
        end
    endtask

    task automatic test_reset_mid_stream();
        int target;
        int bad;
        int rel;
        int d0;
        rx_q.delete();
        send(D1, 1'b0);
        // Middle of data bit 3 of byte 10.
        target = hs_cyc + 10 * FRAME + 4 * CPB + CPB / 2;
        for (int i = 0; i < 12 * FRAME && cyc < target; i++) @(negedge clk);
        d0  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (data_out !== 1'b1 || digest_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: out=%b ready=%b busy=%b, required 1 1 0",
                     data_out, digest_ready, busy);
        end
        rst = 1'b0;
        bad = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (data_out !== 1'b1) bad++;
        end
        checks++;
        if (done_cnt !== d0 || bad !== 0) begin
            errors++;
            $display("FAIL midreset_quiet: done pulses=%0d low cycles=%0d, required 0 0",
                     done_cnt - d0, bad);
        end
        rx_q.delete();
        frame_err = 0;
        send(256'h0, 1'b0);
        wait_done(rel);
        checks++;
        if (rel !== DIGEST_CYC) begin
            errors++;
            $display("FAIL zero_latency: got %0d, required %0d", rel, DIGEST_CYC);
        end
        repeat (5) @(negedge clk);
        bad = 0;
        for (int i = 0; i < NB; i++) if (i >= rx_q.size() || rx_q[i] !== 8'h00) bad++;
        checks++;
        if (rx_q.size() !== NB || bad !== 0 || frame_err !== 0) begin
            errors++;
            $display("FAIL zero_bytes: count=%0d bad=%0d frame_err=%0d, required %0d 0 0",
                     rx_q.size(), bad, frame_err, NB);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        int rel;
        int d0;
        rx_q.delete();
        d0 = done_cnt;
        send(D1, 1'b1);
        wait_done(rel);
        checks++;
        if (rel !== DIGEST_CYC) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d, required %0d", rel, DIGEST_CYC);
        end
        digest_in = D2;
        checks++;
        if (digest_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_ready: ready=%b, required 0", digest_ready);
        end
        @(negedge clk);
        checks++;
        if (digest_ready !== 1'b1 || busy !== 1'b0 || data_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_cycle: ready=%b busy=%b out=%b, required 1 0 1",
                     digest_ready, busy, data_out);
        end
        @(negedge clk);
        hs_cyc = cyc;
        digest_valid = 1'b0;
        checks++;
        if (digest_ready !== 1'b0 || busy !== 1'b1 || data_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: ready=%b busy=%b out=%b, required 0 1 0",
                     digest_ready, busy, data_out);
        end
        wait_done(rel);
        checks++;
        if (rel !== DIGEST_CYC) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d, required %0d", rel, DIGEST_CYC);
        end
        repeat (5) @(negedge clk);
        bad = 0;
        for (int i = 0; i < NB; i++) begin
            if (i >= rx_q.size() || rx_q[i] !== D1[255-8*i -: 8]) bad++;
            if (NB + i >= rx_q.size() || rx_q[NB+i] !== D2[255-8*i -: 8]) bad++;
        end
        checks++;
        if (rx_q.size() !== 2 * NB || bad !== 0) begin
            errors++;
            $display("FAIL b2b_bytes: count=%0d bad=%0d, required %0d 0", rx_q.size(), bad, 2 * NB);
        end
        checks++;
        if (done_cnt - d0 !== 2) begin
            errors++;
            $display("FAIL b2b_done_pulses: got %0d, required 2", done_cnt - d0);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        hs_cyc       = 0;
        done_cnt     = 0;
        frame_err    = 0;
        rst          = 1'b1;
        digest_valid = 1'b0;
        digest_in    = '0;
        test_reset();
        test_single();
        test_ignored_input();
        test_reset_mid_stream();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
